// File: rtl/ecc_regbank_arbiter_pkg.sv
// Shared constants and types for the ECC GF(2^233) operand register bank.
package ecc_regbank_arbiter_pkg;

  localparam int W        = 233;
  localparam int NREQ_DEF = 3;
  localparam int NREG_DEF = 8;
  localparam int AW_DEF   = 3;

  typedef logic [W-1:0]      word_t;
  typedef logic [AW_DEF-1:0] addr_t;

  // Round-robin successor of requester g among n requesters.
  function automatic int rr_next(input int g, input int n);
    return (g + 1) % n;
  endfunction

endpackage

// File: rtl/ecc_regbank_arbiter_if.sv
// Write-request and read-port bundle between the field units and the register bank.
interface ecc_regbank_arbiter_if
  import ecc_regbank_arbiter_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int NREG = NREG_DEF,
  parameter int AW   = AW_DEF
);

  logic                clear;
  logic [NREQ-1:0]     req_valid;
  logic [NREQ-1:0]     req_ready;
  logic [NREQ*AW-1:0]  req_addr;
  logic [NREQ*W-1:0]   req_data;
  logic [AW-1:0]       rd_addr_a;
  word_t               rd_data_a;
  logic [AW-1:0]       rd_addr_b;
  word_t               rd_data_b;
  logic [NREG-1:0]     valid_mask;
  logic                addr_err;

  modport master (
    output clear, req_valid, req_addr, req_data, rd_addr_a, rd_addr_b,
    input  req_ready, rd_data_a, rd_data_b, valid_mask, addr_err
  );

  modport slave (
    input  clear, req_valid, req_addr, req_data, rd_addr_a, rd_addr_b,
    output req_ready, rd_data_a, rd_data_b, valid_mask, addr_err
  );

endinterface

// File: rtl/ecc_regbank_arbiter_word_reg.sv
// One W-bit operand register with synchronous clear and load enable.
module ecc_word_reg
  import ecc_regbank_arbiter_pkg::*;
(
  input  logic  CLK,
  input  logic  RST_N,
  input  logic  i_clear,
  input  logic  i_load,
  input  word_t i_d,
  output word_t o_q
);

  word_t r_q;

  // NOTE: every word is reset explicitly; this bank is flops, not a RAM macro,
  // and the sequencer relies on all operands reading 0 after reset or clear.
  always_ff @(posedge CLK) begin
    if (!RST_N)       r_q <= '0;
    else if (i_clear) r_q <= '0;
    else if (i_load)  r_q <= i_d;
  end

  assign o_q = r_q;

endmodule

// File: rtl/ecc_regbank_arbiter.sv
// Round-robin write arbiter, valid mask and dual read ports around NREG operand words.
module ecc_regbank_arbiter
  import ecc_regbank_arbiter_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int NREG = NREG_DEF,
  parameter int AW   = AW_DEF
)(
  input logic                  CLK,
  input logic                  RST_N,
  ecc_regbank_arbiter_if.slave bus
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [PW-1:0]   r_ptr;
  logic [PW-1:0]   w_ptr_next;
  logic [PW-1:0]   w_grant_idx;
  logic [NREQ-1:0] w_sel;
  logic            w_grant_any;
  logic            w_fire;
  logic [AW-1:0]   w_wr_addr;
  word_t           w_wr_data;
  logic [NREG-1:0] w_load;
  logic [NREG-1:0] r_valid_mask;
  logic            r_addr_err;
  word_t           w_q [NREG];
  word_t           w_rd_a;
  word_t           w_rd_b;

  // Offset k walks outward from the pointer; the first valid requester wins.
  // NOTE: every always_comb output gets a default before the loops, so no latch.
  always_comb begin
    w_grant_any = 1'b0;
    w_grant_idx = r_ptr;
    w_sel       = '0;
    w_wr_addr   = '0;
    w_wr_data   = '0;
    for (int k = 0; k < NREQ; k++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!w_grant_any && bus.req_valid[i] && ((int'(r_ptr) + k) % NREQ == i)) begin
          w_grant_any = 1'b1;
          w_grant_idx = PW'(i);
          w_sel[i]    = 1'b1;
          w_wr_addr   = bus.req_addr[i*AW +: AW];
          w_wr_data   = bus.req_data[i*W +: W];
        end
      end
    end
  end

  // CLEAR and reset suppress the handshake so a write is either whole or absent.
  assign w_fire        = w_grant_any & RST_N & ~bus.clear;
  assign bus.req_ready = w_fire ? w_sel : '0;
  assign w_ptr_next    = PW'(rr_next(int'(w_grant_idx), NREQ));

  // An out-of-range address matches no word, so it loads nothing.
  always_comb begin
    w_load = '0;
    for (int r = 0; r < NREG; r++)
      w_load[r] = w_fire && (w_wr_addr == AW'(r));
  end

  for (genvar g = 0; g < NREG; g++) begin : g_word
    ecc_word_reg u_word (
      .CLK     (CLK),
      .RST_N   (RST_N),
      .i_clear (bus.clear),
      .i_load  (w_load[g]),
      .i_d     (w_wr_data),
      .o_q     (w_q[g])
    );
  end

  // NOTE: non-blocking assignments keep state updates ordered by the clock edge.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_ptr        <= '0;
      r_valid_mask <= '0;
      r_addr_err   <= 1'b0;
    end else begin
      if (w_fire) r_ptr <= w_ptr_next;
      r_addr_err   <= w_fire && (w_load == '0);
      r_valid_mask <= bus.clear ? '0 : (r_valid_mask | w_load);
    end
  end

  // Reads see the registered words only: a same-cycle write shows up next cycle.
  always_comb begin
    w_rd_a = '0;
    w_rd_b = '0;
    for (int r = 0; r < NREG; r++) begin
      if (bus.rd_addr_a == AW'(r)) w_rd_a = w_q[r];
      if (bus.rd_addr_b == AW'(r)) w_rd_b = w_q[r];
    end
  end

  assign bus.rd_data_a  = w_rd_a;
  assign bus.rd_data_b  = w_rd_b;
  assign bus.valid_mask = r_valid_mask;
  assign bus.addr_err   = r_addr_err;

endmodule

// File: tb/tb_ecc_regbank_arbiter.sv
// Randomized bench for ecc_regbank_arbiter against a behavioural bank model.
module tb_ecc_regbank_arbiter;
  import ecc_regbank_arbiter_pkg::*;

  localparam int NREQ = 3;
  localparam int NREG = 8;
  localparam int AW   = 4;

  logic CLK = 1'b0;
  logic RST_N;
  always #5 CLK = ~CLK;

  ecc_regbank_arbiter_if #(.NREQ(NREQ), .NREG(NREG), .AW(AW)) bus ();

  ecc_regbank_arbiter #(.NREQ(NREQ), .NREG(NREG), .AW(AW)) dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Behavioural model of the bank.
  word_t           m_reg [NREG];
  logic [NREG-1:0] m_mask;
  int              m_ptr;
  logic            m_err;

  // Requester and read-port stimulus state.
  logic          rq_v    [NREQ];
  logic [AW-1:0] rq_a    [NREQ];
  word_t         rq_d    [NREQ];
  int            rq_wait [NREQ];
  logic          clear;
  logic [AW-1:0] ra, rb;
  int            dut_grant;
  int            exp_seq [4] = '{0, 1, 2, 0};
  word_t         d1, old_b;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic word_t rand_word();
    word_t w = '0;
    for (int i = 0; i < 8; i++) w = {w[W-33:0], $urandom()};
    return w;
  endfunction

  function automatic word_t model_read(input logic [AW-1:0] a);
    if (int'(a) < NREG) return m_reg[int'(a)];
    return '0;
  endfunction

  task automatic drive();
    bus.clear     = clear;
    bus.rd_addr_a = ra;
    bus.rd_addr_b = rb;
    for (int i = 0; i < NREQ; i++) begin
      bus.req_valid[i]           = rq_v[i];
      bus.req_addr[i*AW +: AW]   = rq_a[i];
      bus.req_data[i*W +: W]     = rq_d[i];
    end
  endtask

  // Drive, check outputs mid-cycle, clock once, then advance the model.
  task automatic cycle();
    int g;
    logic [NREQ-1:0] exp_ready;
    drive();
    #1;
    g = -1;
    if (RST_N && !clear)
      for (int k = 0; k < NREQ; k++)
        if (g < 0 && rq_v[(m_ptr + k) % NREQ]) g = (m_ptr + k) % NREQ;
    exp_ready = '0;
    if (g >= 0) exp_ready[g] = 1'b1;
    dut_grant = -1;
    for (int i = 0; i < NREQ; i++)
      if (bus.req_ready[i]) dut_grant = (dut_grant == -1) ? i : -2;
    check("req_ready", bus.req_ready, exp_ready);
    check("rd_data_a", bus.rd_data_a, model_read(ra));
    check("rd_data_b", bus.rd_data_b, model_read(rb));
    check("valid_mask", bus.valid_mask, m_mask);
    check("addr_err", bus.addr_err, m_err);
    if (g >= 0 && dut_grant == g) check("starvation_bound", rq_wait[g] < NREQ, 1'b1);
    @(posedge CLK);
    #1;
    if (!RST_N) begin
      for (int r = 0; r < NREG; r++) m_reg[r] = '0;
      m_mask = '0;
      m_ptr  = 0;
      m_err  = 1'b0;
    end else if (clear) begin
      for (int r = 0; r < NREG; r++) m_reg[r] = '0;
      m_mask = '0;
      m_err  = 1'b0;
    end else begin
      m_err = 1'b0;
      if (g >= 0) begin
        if (int'(rq_a[g]) < NREG) begin
          m_reg[int'(rq_a[g])]  = rq_d[g];
          m_mask[int'(rq_a[g])] = 1'b1;
        end else begin
          m_err = 1'b1;
        end
        m_ptr = (g + 1) % NREQ;
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      if (i == g) begin
        rq_v[i]    = 1'b0;
        rq_wait[i] = 0;
      end else if (!RST_N) begin
        rq_wait[i] = 0;
      end else if (rq_v[i] && !clear) begin
        rq_wait[i]++;
      end
    end
  endtask

  initial begin
    for (int r = 0; r < NREG; r++) m_reg[r] = '0;
    m_mask = '0;
    m_ptr  = 0;
    m_err  = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      rq_v[i]    = 1'b0;
      rq_a[i]    = '0;
      rq_d[i]    = '0;
      rq_wait[i] = 0;
    end
    clear = 1'b0;
    ra    = 4'd5;
    rb    = 4'd5;
    RST_N = 1'b0;
    drive();
    @(posedge CLK);
    #1;

    // Reset: a pending request must not be granted while RST_N is low.
    rq_v[0] = 1'b1;
    rq_a[0] = 4'd1;
    rq_d[0] = rand_word();
    cycle();
    check("reset_no_grant", dut_grant, -1);
    rq_v[0] = 1'b0;
    cycle();
    check("reset_mask", bus.valid_mask, 8'h00);
    RST_N = 1'b1;

    // Single write from requester 1.
    d1 = rand_word();
    d1[3:0]  = 4'hF;
    d1[W-1]  = 1'b1;
    rq_v[1]  = 1'b1;
    rq_a[1]  = 4'd3;
    rq_d[1]  = d1;
    ra       = 4'd3;
    cycle();
    check("single_grant", dut_grant, 1);
    check("single_mask", bus.valid_mask, 8'h08);
    check("single_data", bus.rd_data_a, d1);

    // Requester 2 alone brings the pointer back to 0.
    rq_v[2] = 1'b1;
    rq_a[2] = 4'd0;
    rq_d[2] = rand_word();
    cycle();
    check("ptr_wrap_grant", dut_grant, 2);

    // Contention: all requesters held valid, round-robin order from pointer 0.
    for (int s = 0; s < 4; s++) begin
      for (int i = 0; i < NREQ; i++)
        if (!rq_v[i]) begin
          rq_v[i] = 1'b1;
          rq_a[i] = AW'($urandom_range(0, NREG - 1));
          rq_d[i] = rand_word();
        end
      cycle();
      check("contention_order", dut_grant, exp_seq[s]);
    end
    for (int n = 0; n < 4; n++) cycle();

    // Read during write: port B sees the old word, then the new one.
    rb      = 4'd2;
    old_b   = model_read(4'd2);
    rq_v[0] = 1'b1;
    rq_a[0] = 4'd2;
    rq_d[0] = W'(8'hAA);
    drive();
    #1;
    check("rdw_old", bus.rd_data_b, old_b);
    cycle();
    check("rdw_new", bus.rd_data_b, W'(8'hAA));

    // CLEAR collides with a pending request.
    clear   = 1'b1;
    rq_v[0] = 1'b1;
    rq_a[0] = 4'd4;
    rq_d[0] = rand_word();
    cycle();
    check("clear_no_grant", dut_grant, -1);
    check("clear_mask", bus.valid_mask, 8'h00);
    check("clear_data", bus.rd_data_b, '0);
    clear = 1'b0;
    cycle();
    check("clear_regrant", dut_grant, 0);

    // Out-of-range write address.
    rq_v[2] = 1'b1;
    rq_a[2] = 4'd9;
    rq_d[2] = rand_word();
    cycle();
    check("bad_grant", dut_grant, 2);
    check("bad_err", bus.addr_err, 1'b1);
    check("bad_mask", bus.valid_mask, 8'h10);
    cycle();
    check("bad_err_once", bus.addr_err, 1'b0);

    // Randomized traffic with occasional CLEAR and reset.
    for (int n = 0; n < 400; n++) begin
      RST_N = ($urandom_range(0, 99) != 0);
      clear = ($urandom_range(0, 19) == 0);
      ra    = AW'($urandom_range(0, 15));
      rb    = AW'($urandom_range(0, 15));
      for (int i = 0; i < NREQ; i++)
        if (!rq_v[i] && $urandom_range(0, 2) != 0) begin
          rq_v[i] = 1'b1;
          rq_a[i] = AW'($urandom_range(0, 9));
          rq_d[i] = rand_word();
        end
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
